// File: rtl/logic_op_word_decoder.sv
// Receive-side decoder for parity-protected 3-bit logic-op words.
// Each accepted word is classified (at-most-one-hot, any-set, parity error)
// and queued in a 2-entry FIFO. Word/error statistics are kept. A run of
// consecutive parity errors locks the input side until clear or rst.
module logic_op_word_decoder #(
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 3,
  parameter int DROP_ERR  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [2:0]       m_data,
  output logic             m_le1,
  output logic             m_any,
  output logic             m_perr,
  input  logic             clear,
  output logic             locked,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic       perr;
    logic       any;
    logic       le1;
    logic [2:0] data;
  } entry_t;

  typedef enum logic {RUN, LOCKED} state_t;

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MX = '1;

  state_t             state_q, state_d;
  entry_t [1:0]       mem;
  logic   [1:0]       cnt, cnt_d;
  logic   [CNT_W-1:0] consec;
  entry_t             in_word;
  logic               acc, pop, push, wr_idx, run;

  assign run     = (state_q == RUN);
  assign m_valid = (cnt != 2'd0);
  assign pop     = m_valid && m_ready;
  // Locked mode swallows everything; in RUN a full FIFO may still accept
  // when the head leaves at the same edge.
  assign s_ready = run ? ((cnt < 2'd2) || pop) : 1'b1;
  assign acc     = s_valid && s_ready;
  assign locked  = !run;

  assign m_data  = mem[0].data;
  assign m_le1   = mem[0].le1;
  assign m_any   = mem[0].any;
  assign m_perr  = mem[0].perr;

  // Classify the incoming word.
  always_comb begin
    in_word      = '0;
    in_word.data = s_data[2:0];
    in_word.perr = s_data[3] ^ (^s_data[2:0]);
    in_word.le1  = ~((s_data[0] & s_data[1]) | (s_data[0] & s_data[2]) |
                     (s_data[1] & s_data[2]));
    in_word.any  = |s_data[2:0];
  end

  // FIFO control: push slot is the first free entry after any pop.
  always_comb begin
    push   = acc && run && !(in_word.perr && (DROP_ERR != 0));
    wr_idx = (cnt == 2'd2) || ((cnt == 2'd1) && !pop);
    cnt_d  = cnt + 2'(push) - 2'(pop);
  end

  // FIFO storage; entry 0 is always the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      cnt <= 2'd0;
    end else if (clear) begin
      mem <= '0;
      cnt <= 2'd0;
    end else begin
      if (pop && (cnt == 2'd2)) mem[0] <= mem[1];
      if (push) mem[wr_idx] <= in_word;
      cnt <= cnt_d;
    end
  end

  // Next-state: lock when this accept completes the error run.
  always_comb begin
    state_d = state_q;
    if (clear)
      state_d = RUN;
    else if (run && acc && in_word.perr && (consec + 1'b1 == LIM))
      state_d = LOCKED;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Statistics and consecutive-error tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      err_cnt  <= '0;
      consec   <= '0;
    end else if (clear) begin
      word_cnt <= '0;
      err_cnt  <= '0;
      consec   <= '0;
    end else if (acc) begin
      if (in_word.perr && (err_cnt != CNT_MX)) err_cnt <= err_cnt + 1'b1;
      if (run) begin
        word_cnt <= word_cnt + 1'b1;
        consec   <= in_word.perr ? consec + 1'b1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_logic_op_word_decoder.sv
// Directed bench for logic_op_word_decoder. Instance A uses the default
// parameters (drop errored words); instance B uses a 2-bit counter width
// and keeps errored words in the FIFO.
module tb_logic_op_word_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A signals
  logic       a_s_valid = 0, a_s_ready, a_m_valid, a_m_ready = 0;
  logic [3:0] a_s_data = 0;
  logic [2:0] a_m_data;
  logic       a_m_le1, a_m_any, a_m_perr, a_clear = 0, a_locked;
  logic [7:0] a_word_cnt, a_err_cnt;

  // Instance B signals
  logic       b_s_valid = 0, b_s_ready, b_m_valid, b_m_ready = 0;
  logic [3:0] b_s_data = 0;
  logic [2:0] b_m_data;
  logic       b_m_le1, b_m_any, b_m_perr, b_clear = 0, b_locked;
  logic [1:0] b_word_cnt, b_err_cnt;

  logic_op_word_decoder #(.CNT_W(8), .ERR_LIMIT(3), .DROP_ERR(1)) u_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .s_data(a_s_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
    .m_data(a_m_data), .m_le1(a_m_le1), .m_any(a_m_any), .m_perr(a_m_perr),
    .clear(a_clear), .locked(a_locked), .word_cnt(a_word_cnt),
    .err_cnt(a_err_cnt)
  );

  logic_op_word_decoder #(.CNT_W(2), .ERR_LIMIT(3), .DROP_ERR(0)) u_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_data(b_s_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_data(b_m_data), .m_le1(b_m_le1), .m_any(b_m_any), .m_perr(b_m_perr),
    .clear(b_clear), .locked(b_locked), .word_cnt(b_word_cnt),
    .err_cnt(b_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] le1_tab;

  initial begin
    le1_tab = 8'b0001_0111; // bit d = expected le1 for data d

    // ---- reset state
    #1;
    chk("rst_m_valid", 32'(a_m_valid), 0);
    chk("rst_s_ready", 32'(a_s_ready), 1);
    chk("rst_locked",  32'(a_locked), 0);
    chk("rst_word",    32'(a_word_cnt), 0);
    chk("rst_err",     32'(a_err_cnt), 0);
    chk("rst_head",    32'({a_m_perr, a_m_any, a_m_le1, a_m_data}), 0);
    step();
    rst = 0;
    step();

    // ---- 8 good words, streaming
    a_m_ready = 1;
    for (int d = 0; d < 8; d++) begin
      a_s_valid = 1;
      a_s_data  = {^3'(d), 3'(d)};
      step();
      chk("t1_valid", 32'(a_m_valid), 1);
      chk("t1_data",  32'(a_m_data), 32'(d));
      chk("t1_le1",   32'(a_m_le1), 32'(le1_tab[d]));
      chk("t1_any",   32'(a_m_any), 32'(d != 0));
      chk("t1_perr",  32'(a_m_perr), 0);
    end
    a_s_valid = 0;
    step();
    chk("t1_drained", 32'(a_m_valid), 0);
    chk("t1_word",    32'(a_word_cnt), 8);
    chk("t1_err",     32'(a_err_cnt), 0);

    // ---- backpressure and push-while-full
    a_m_ready = 0;
    a_s_valid = 1; a_s_data = 4'b1001;
    chk("t2_rdy0", 32'(a_s_ready), 1);
    step();
    a_s_data = 4'b1010;
    chk("t2_rdy1", 32'(a_s_ready), 1);
    step();
    a_s_data = 4'b0011;
    chk("t2_full", 32'(a_s_ready), 0);
    step();
    chk("t2_hold", 32'(a_m_data), 1);
    chk("t2_word_hold", 32'(a_word_cnt), 10);
    a_m_ready = 1;
    #1;
    chk("t2_rdy_pop", 32'(a_s_ready), 1);
    step();
    chk("t2_head2", 32'(a_m_data), 2);
    chk("t2_rdy_after", 32'(a_s_ready), 1);
    a_s_valid = 0;
    step();
    chk("t2_head3", 32'(a_m_data), 3);
    chk("t2_v3",    32'(a_m_valid), 1);
    step();
    chk("t2_empty", 32'(a_m_valid), 0);
    chk("t2_word",  32'(a_word_cnt), 11);

    // ---- dropped parity error then good word
    a_s_valid = 1; a_s_data = 4'b0001;
    step();
    chk("t3_drop",  32'(a_m_valid), 0);
    chk("t3_err",   32'(a_err_cnt), 1);
    a_s_data = 4'b1001;
    step();
    chk("t3_good_v", 32'(a_m_valid), 1);
    chk("t3_good_d", 32'(a_m_data), 1);
    chk("t3_word",   32'(a_word_cnt), 13);

    // ---- three consecutive errors lock (would lock early if consec had not reset)
    a_s_data = 4'b0001;
    step();
    chk("t4_lock1", 32'(a_locked), 0);
    step();
    chk("t4_lock2", 32'(a_locked), 0);
    step();
    chk("t4_lock3", 32'(a_locked), 1);
    chk("t4_err",   32'(a_err_cnt), 4);
    chk("t4_word",  32'(a_word_cnt), 16);
    a_s_data = 4'b1001;
    chk("t4_rdy_lk", 32'(a_s_ready), 1);
    step();
    step();
    chk("t4_no_out",  32'(a_m_valid), 0);
    chk("t4_frozen",  32'(a_word_cnt), 16);
    a_s_data = 4'b0111;
    step();
    chk("t4_err_lk",  32'(a_err_cnt), 5);
    a_clear = 1; a_s_data = 4'b1001;
    step();
    a_clear = 0; a_s_valid = 0;
    chk("t4_clr_lock", 32'(a_locked), 0);
    chk("t4_clr_word", 32'(a_word_cnt), 0);
    chk("t4_clr_err",  32'(a_err_cnt), 0);
    chk("t4_clr_fifo", 32'(a_m_valid), 0);

    // ---- counter wrap / saturation on 2-bit instance, errors kept
    b_m_ready = 1;
    b_s_valid = 1; b_s_data = 4'b0101;
    for (int i = 0; i < 5; i++) step();
    chk("t5_wrap", 32'(b_word_cnt), 1);
    b_s_data = 4'b1011;
    step();
    chk("t5_perr_v",  32'(b_m_valid), 1);
    chk("t5_perr",    32'(b_m_perr), 1);
    chk("t5_perr_d",  32'(b_m_data), 3);
    chk("t5_perr_le", 32'(b_m_le1), 0);
    step();
    step();
    chk("t5_locked",  32'(b_locked), 1);
    chk("t5_word",    32'(b_word_cnt), 0);
    step();
    step();
    b_s_valid = 0;
    chk("t5_sat",     32'(b_err_cnt), 3);
    chk("t5_still",   32'(b_locked), 1);
    chk("t5_drained", 32'(b_m_valid), 0);

    // ---- async reset with FIFO full
    a_m_ready = 0;
    a_s_valid = 1; a_s_data = 4'b1001;
    step();
    a_s_data = 4'b1010;
    step();
    a_s_valid = 0;
    chk("t6_full_rdy", 32'(a_s_ready), 0);
    chk("t6_word",     32'(a_word_cnt), 2);
    #2 rst = 1;
    #1;
    chk("t6_rst_v",    32'(a_m_valid), 0);
    chk("t6_rst_word", 32'(a_word_cnt), 0);
    chk("t6_rst_rdy",  32'(a_s_ready), 1);
    chk("t6_rst_b",    32'(b_locked), 0);
    step();
    rst = 0;
    step();
    chk("t6_post_v", 32'(a_m_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_op_word_decoder.md
Name: logic_op_word_decoder

Overview:
Receive-side decoder for 3-bit logic-op words sent with a parity bit by the upstream encoder. The block checks parity and classifies each word: at-most-one-hot, any-bit-set, and parity. Classified words are buffered in a 2-entry output FIFO under valid/ready handshakes on both sides. The block also keeps word and error statistics and locks out after a run of consecutive parity errors.

Parameters:
CNT_W, 8, width of word_cnt and err_cnt
ERR_LIMIT, 3, consecutive parity errors that force LOCKED (1..2^CNT_W-1)
DROP_ERR, 1, 1 = parity-failed words are counted but not pushed to FIFO; 0 = pushed with m_perr=1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
s_valid  input  1  input word valid
s_ready  output  1  decoder can accept a word
s_data  input  4  [3]=parity (even: s_data[3] == ^s_data[2:0]), [2:0]=data
m_valid  output  1  FIFO head valid
m_ready  input  1  downstream accepts head
m_data  output  3  head data bits
m_le1  output  1  head has popcount(data) <= 1
m_any  output  1  head has |data
m_perr  output  1  head failed parity (only possible when DROP_ERR=0)
clear  input  1  synchronous: zero counters, flush FIFO, return to RUN
locked  output  1  high in LOCKED state
word_cnt  output  CNT_W  accepted words, wraps
err_cnt  output  CNT_W  parity errors, saturates at all-ones

Behaviour:
- Reset (async, immediate): FIFO empty, m_valid=0, m_data/m_le1/m_any/m_perr=0, state=RUN, locked=0, word_cnt=0, err_cnt=0, consecutive-error counter=0. s_ready is combinational and reads 1 right after reset.
- Accept: an accept occurs when s_valid && s_ready at a rising edge. The block never holds s_ready low waiting on s_valid.
- Classification at accept: perr = s_data[3] ^ (^s_data[2:0]); le1 = ~((d0&d1)|(d0&d2)|(d1&d2)); any = |d.
- FIFO: 2 entries, 6 bits each {perr, any, le1, data}. Outputs come from the head register.
  - Latency: a word accepted at edge N gives m_valid=1 after edge N.
  - s_ready = state==RUN ? (count<2 || (m_valid && m_ready)) : 1. Simultaneous pop and push at full is allowed.
  - Pop when m_valid && m_ready. Head contents stay stable while m_valid && !m_ready.
- States:
  - RUN: every accepted word increments word_cnt (mod 2^CNT_W).
    - Parity error: err_cnt++ (saturating) and consec++. Push unless DROP_ERR=1.
    - Good word: consec=0 and the word is pushed.
    - When consec reaches ERR_LIMIT on an accept, go to LOCKED at the same edge. That erroring word is handled per DROP_ERR as usual.
  - LOCKED: locked=1 and s_ready=1.
    - Accepted words are discarded. Discarded words do not change word_cnt; parity errors on them still increment err_cnt (saturating).
    - The FIFO keeps draining normally.
    - Only clear or rst leaves LOCKED.
- clear (synchronous, highest priority after rst): at the edge, FIFO becomes empty, counters and consec reset to 0, state=RUN. A word presented in the same cycle is accepted by handshake but dropped and not counted.
- Counters: word_cnt wraps from all-ones to 0; err_cnt holds at all-ones.
- rst asserted mid-transfer: all state clears at once. Words in flight are lost and no partial output is produced.

Test Plan:
- Reset, then send 8 good words d=0..7 with m_ready=1 -> m_le1 = 1,1,1,0,1,0,0,0; m_any=0 only for d=0; m_perr=0; word_cnt=8; err_cnt=0; each word appears one cycle after its accept.
- m_ready=0, send 3 good words -> s_ready drops after 2 accepts. Raise m_ready and push in the same cycle -> no loss, order preserved, s_ready stays 1.
- DROP_ERR=1, send s_data=4'b0001 (bad parity) then 4'b1001 (good) -> only data=001 emerges; err_cnt=1; word_cnt=2; consec returns to 0.
- ERR_LIMIT=3, send 3 bad words -> locked=1 after the 3rd accept. Further good words are consumed with s_ready=1 but not output; word_cnt frozen at 3. Assert clear -> locked=0, counters=0, FIFO empty.
- CNT_W=2, send 5 good words -> word_cnt reads 1. Send 5 bad words with ERR_LIMIT=3 -> err_cnt holds at 3 in LOCKED.
- Assert rst asynchronously between edges with the FIFO full -> m_valid=0 and counters=0 immediately, before the next clk edge.
